// File: rtl/pixel_block_addr_gen.sv
// pixel_block_addr_gen
//   Sequential pixel-to-block address generator. The raster position is
//   tracked internally from a pixel strobe, and each consumed pixel produces
//   one registered result a cycle later. The result carries the block address
//   (block_row*COLS + block_col), the pixel x/y, the block column/row and the
//   offsets inside the block. Per-axis sub-block counters and a row-base
//   accumulator replace any multiply or divide.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   frame_start_i  restart position at (0,0); clears overrun
//   pix_valid_i    one pixel consumed at the current position
//   addr_valid_o   one-cycle strobe: outputs below hold a new result
//   addr_o         block address
//   x_out_o        pixel x
//   y_out_o        pixel y
//   blk_col_o      block column
//   blk_row_o      block row
//   sub_x_o        x offset inside block
//   sub_y_o        y offset inside block
//   frame_done_o   one-cycle pulse alongside the last pixel's result
//   overrun_o      sticky: pixel strobe seen after the frame completed
module pixel_block_addr_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BLK_W    = 10,
  parameter int BLK_H    = 10,
  parameter int ADDR_W   = 12,
  localparam int COLS    = (H_ACTIVE + BLK_W - 1) / BLK_W,
  localparam int ROWS    = (V_ACTIVE + BLK_H - 1) / BLK_H,
  localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1,
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int SXW     = (BLK_W > 1) ? $clog2(BLK_W) : 1,
  localparam int SYW     = (BLK_H > 1) ? $clog2(BLK_H) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start_i,
  input  logic              pix_valid_i,
  output logic              addr_valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [XW-1:0]     x_out_o,
  output logic [YW-1:0]     y_out_o,
  output logic [CW-1:0]     blk_col_o,
  output logic [RW-1:0]     blk_row_o,
  output logic [SXW-1:0]    sub_x_o,
  output logic [SYW-1:0]    sub_y_o,
  output logic              frame_done_o,
  output logic              overrun_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

  localparam logic [XW-1:0]     X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [SXW-1:0]    SX_LAST  = SXW'(BLK_W - 1);
  localparam logic [SYW-1:0]    SY_LAST  = SYW'(BLK_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

  state_e state_q, state_d;

  // position counters (next pixel to be consumed)
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [SXW-1:0]    sx_q, sx_d;
  logic [SYW-1:0]    sy_q, sy_d;
  logic [CW-1:0]     bc_q, bc_d;
  logic [RW-1:0]     br_q, br_d;
  logic [ADDR_W-1:0] rb_q, rb_d;

  // registered result
  logic              av_q, av_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     xo_q, xo_d;
  logic [YW-1:0]     yo_q, yo_d;
  logic [CW-1:0]     co_q, co_d;
  logic [RW-1:0]     ro_q, ro_d;
  logic [SXW-1:0]    sxo_q, sxo_d;
  logic [SYW-1:0]    syo_q, syo_d;
  logic              fd_q, fd_d;
  logic              ovr_q, ovr_d;

  // position of the pixel consumed this cycle
  logic [XW-1:0]     cur_x;
  logic [YW-1:0]     cur_y;
  logic [SXW-1:0]    cur_sx;
  logic [SYW-1:0]    cur_sy;
  logic [CW-1:0]     cur_bc;
  logic [RW-1:0]     cur_br;
  logic [ADDR_W-1:0] cur_rb;
  logic              consume;

  always_comb begin
    // frame_start overrides the tracked position so a same-cycle pixel is (0,0)
    cur_x   = frame_start_i ? '0 : x_q;
    cur_y   = frame_start_i ? '0 : y_q;
    cur_sx  = frame_start_i ? '0 : sx_q;
    cur_sy  = frame_start_i ? '0 : sy_q;
    cur_bc  = frame_start_i ? '0 : bc_q;
    cur_br  = frame_start_i ? '0 : br_q;
    cur_rb  = frame_start_i ? '0 : rb_q;
    consume = pix_valid_i && (frame_start_i || (state_q == ACTIVE));

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    bc_d    = bc_q;
    br_d    = br_q;
    rb_d    = rb_q;
    av_d    = 1'b0;
    fd_d    = 1'b0;
    addr_d  = addr_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    co_d    = co_q;
    ro_d    = ro_q;
    sxo_d   = sxo_q;
    syo_d   = syo_q;
    ovr_d   = ovr_q;

    if (frame_start_i) begin
      state_d = ACTIVE;
      x_d     = '0;
      y_d     = '0;
      sx_d    = '0;
      sy_d    = '0;
      bc_d    = '0;
      br_d    = '0;
      rb_d    = '0;
      ovr_d   = 1'b0;
    end else if ((state_q == DONE) && pix_valid_i) begin
      ovr_d = 1'b1;
    end

    if (consume) begin
      av_d   = 1'b1;
      addr_d = cur_rb + ADDR_W'(cur_bc);
      xo_d   = cur_x;
      yo_d   = cur_y;
      co_d   = cur_bc;
      ro_d   = cur_br;
      sxo_d  = cur_sx;
      syo_d  = cur_sy;

      if (cur_x == X_LAST) begin
        // line wrap; a partial last block is cut short here
        x_d  = '0;
        sx_d = '0;
        bc_d = '0;
        if (cur_y == Y_LAST) begin
          y_d     = '0;
          sy_d    = '0;
          br_d    = '0;
          rb_d    = '0;
          fd_d    = 1'b1;
          state_d = DONE;
        end else begin
          y_d = cur_y + YW'(1);
          if (cur_sy == SY_LAST) begin
            sy_d = '0;
            br_d = cur_br + RW'(1);
            rb_d = cur_rb + ROW_STEP;
          end else begin
            sy_d = cur_sy + SYW'(1);
            br_d = cur_br;
            rb_d = cur_rb;
          end
        end
      end else begin
        x_d  = cur_x + XW'(1);
        y_d  = cur_y;
        sy_d = cur_sy;
        br_d = cur_br;
        rb_d = cur_rb;
        if (cur_sx == SX_LAST) begin
          sx_d = '0;
          bc_d = cur_bc + CW'(1);
        end else begin
          sx_d = cur_sx + SXW'(1);
          bc_d = cur_bc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      bc_q    <= '0;
      br_q    <= '0;
      rb_q    <= '0;
      av_q    <= 1'b0;
      addr_q  <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      co_q    <= '0;
      ro_q    <= '0;
      sxo_q   <= '0;
      syo_q   <= '0;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      bc_q    <= bc_d;
      br_q    <= br_d;
      rb_q    <= rb_d;
      av_q    <= av_d;
      addr_q  <= addr_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      co_q    <= co_d;
      ro_q    <= ro_d;
      sxo_q   <= sxo_d;
      syo_q   <= syo_d;
      fd_q    <= fd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign addr_valid_o = av_q;
  assign addr_o       = addr_q;
  assign x_out_o      = xo_q;
  assign y_out_o      = yo_q;
  assign blk_col_o    = co_q;
  assign blk_row_o    = ro_q;
  assign sub_x_o      = sxo_q;
  assign sub_y_o      = syo_q;
  assign frame_done_o = fd_q;
  assign overrun_o    = ovr_q;

endmodule

// File: doc/pixel_block_addr_gen.md
Name: pixel_block_addr_gen

Overview:
- Sequential, parametrised successor to the combinational pixel-to-block address mapper.
- Tracks the raster position internally from a pixel strobe; emits block address, block column/row and in-block offsets one cycle later.
- No multiplier or divider: uses per-axis sub-block counters and a row-base accumulator.
- Sits between the VGA timing generator and the block/tile memory read port.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BLK_W, 10, block width in pixels (>=1)
- BLK_H, 10, block height in lines (>=1)
- ADDR_W, 12, block address width; must hold COLS*ROWS-1
- Derived localparams: COLS = ceil(H_ACTIVE/BLK_W), ROWS = ceil(V_ACTIVE/BLK_H); coordinate widths = clog2 of each range.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  pulse; restarts position at (0,0)
- pix_valid  in  1  one pixel consumed at the current position this cycle
- addr_valid  out  1  outputs below hold a new pixel result
- addr  out  ADDR_W  block_row*COLS + block_col
- x_out  out  clog2(H_ACTIVE)  pixel x
- y_out  out  clog2(V_ACTIVE)  pixel y
- blk_col  out  clog2(COLS)  block column
- blk_row  out  clog2(ROWS)  block row
- sub_x  out  clog2(BLK_W)  x offset inside block
- sub_y  out  clog2(BLK_H)  y offset inside block
- frame_done  out  1  one-cycle pulse with the last pixel's result
- overrun  out  1  sticky; pix_valid seen after frame completion

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, all counters 0.
- States:
  - IDLE: pix_valid ignored, no flag. frame_start -> ACTIVE.
  - ACTIVE: consume pixels; last pixel -> DONE.
  - DONE: pix_valid sets overrun, no output. frame_start -> ACTIVE.
- frame_start in any state:
  - Clears position, row base and overrun.
  - If pix_valid is high in the same cycle, that pixel is (0,0) and the position advances to (1,0).
- Latency: a pixel consumed at edge t gives registered outputs valid after edge t+1. addr_valid is high for exactly one cycle per consumed pixel; all other outputs hold between pixels.
- pix_valid low: no advance; gaps of any length are allowed.
- x advance: sub_x increments; at BLK_W-1 it wraps to 0 and blk_col increments.
- Line wrap at x = H_ACTIVE-1: x, sub_x and blk_col return to 0; y advances the same way via sub_y/blk_row.
- Row base: row_base += COLS when blk_row increments; addr = row_base + blk_col, computed with one adder.
- Partial blocks: if H_ACTIVE or V_ACTIVE is not a multiple of the block size, the last partial block is a full column/row index. Its sub counter is cut short by the line/frame wrap.
- Last pixel (H_ACTIVE-1, V_ACTIVE-1): result output with frame_done = 1 in the same cycle; state -> DONE; counters return to 0.
- Reset mid-frame: immediate return to reset values; no partial result is emitted.
- Arithmetic: all counters are unsigned and never exceed their stated range. No wrap past ROWS.

Test Plan:
1. Reset and first pixel: rst_n low -> all outputs 0. Release, frame_start + pix_valid in one cycle -> next cycle addr_valid = 1, x = 0, y = 0, addr = 0x000.
2. Horizontal block boundary: pixels x = 9 then x = 10 on y = 0 -> addr 0x000 then 0x001; sub_x 9 then 0; blk_col 0 then 1.
3. Line and row wrap: x = 639, y = 9 -> addr 0x03F. Next pixel is x = 0, y = 10 -> addr 0x040, blk_row = 1, sub_y = 0.
4. Frame end and overrun:
   - Pixel (639,479) -> addr 0xBFF with frame_done = 1.
   - Extra pix_valid -> no addr_valid, overrun = 1.
   - frame_start -> overrun = 0.
5. Mid-frame frame_start and gaps: random pix_valid gaps, then frame_start at (300,200) -> next pixel is (0,0), addr 0. The full frame yields exactly 307200 addr_valid pulses, and addr matches (y/10)*64 + x/10 every time.
6. Non-default parameters: H_ACTIVE = 100, V_ACTIVE = 30, BLK_W = 16, BLK_H = 8 -> COLS = 7, ROWS = 4. Pixel (99,29) -> blk_col 6, blk_row 3, addr 27, sub_x 3, sub_y 5, frame_done = 1.
